// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: sequencer states and frame constants.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick is high on the last clock of each serial bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_reg;

    // Wrapping on tick restarts the count at every bit boundary without help from the sequencer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr || tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tick = (count_reg == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// Drains bytes from an upstream FIFO and serialises each one as an 8N1 (or 8E1) UART frame.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    input  logic [7:0] fifo_dout,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t      state_reg, state_next;
    logic [7:0]     shift_reg, shift_next;
    logic [2:0]     bit_idx_reg, bit_idx_next;
    logic           parity_reg, parity_next;
    logic           tx_reg, tx_next;
    logic           baud_clr;
    logic           baud_tick;

    // The counter only runs while a bit is on the line.
    assign baud_clr = (state_reg == ST_IDLE) || (state_reg == ST_FETCH) || (state_reg == ST_LOAD);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .tick (baud_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            parity_reg  <= 1'b0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_idx_reg <= bit_idx_next;
            parity_reg  <= parity_next;
            tx_reg      <= tx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        parity_next  = parity_reg;
        tx_next      = 1'b1;

        case (state_reg)
            ST_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                shift_next   = fifo_dout;
                parity_next  = even_parity(fifo_dout);
                bit_idx_next = '0;
                state_next   = ST_START;
            end
            ST_START: begin
                if (baud_tick) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_idx_reg == LAST_BIT) begin
                        state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    state_next = (enable && !fifo_empty) ? ST_FETCH : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Line level is decoded from the upcoming state so tx leaves a flop aligned with it.
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_next[0];
            ST_PARITY: tx_next = parity_next;
            default:   tx_next = 1'b1;
        endcase
    end

    assign tx         = tx_reg;
    assign fifo_rd    = (state_reg == ST_FETCH);
    assign busy       = (state_reg != ST_IDLE);
    assign frame_done = (state_reg == ST_STOP) && baud_tick;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Randomised scoreboard bench: two instances (no parity / even parity) fed by FIFO models.
module tb_uart_tx_drain;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       fifo_empty_w [2];
    logic       fifo_rd_w    [2];
    logic [7:0] fifo_dout_r  [2];
    logic       tx_w         [2];
    logic       busy_w       [2];
    logic       frame_done_w [2];

    logic [7:0] fbuf [2][64];
    logic [7:0] ebuf [2][64];
    int         fhead [2];
    int         ftail [2];
    int         ehead [2];
    int         etail [2];

    int n_vec;
    int n_err;

    assign fifo_empty_w[0] = (fhead[0] == ftail[0]);
    assign fifo_empty_w[1] = (fhead[1] == ftail[1]);

    uart_tx_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty_w[0]),
        .fifo_rd(fifo_rd_w[0]), .fifo_dout(fifo_dout_r[0]), .tx(tx_w[0]),
        .busy(busy_w[0]), .frame_done(frame_done_w[0])
    );

    uart_tx_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty_w[1]),
        .fifo_rd(fifo_rd_w[1]), .fifo_dout(fifo_dout_r[1]), .tx(tx_w[1]),
        .busy(busy_w[1]), .frame_done(frame_done_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: data appears on fifo_dout the cycle after the read strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst && fifo_rd_w[i]) begin
                n_vec++;
                if (fhead[i] == ftail[i]) begin
                    n_err++;
                    $display("FAIL rd_empty dut%0d: fifo_rd=1 with empty fifo, required 0", i);
                end else begin
                    fifo_dout_r[i] = fbuf[i][fhead[i] % 64];
                    fhead[i]++;
                end
            end
        end
    end

    // Reference line level: start, 8 data bits LSB first, optional even parity, stop.
    function automatic logic exp_level(input logic [7:0] b, input int p, input int k);
        int bit_no;
        bit_no = k / CPB;
        if (bit_no == 0) return 1'b0;
        if (bit_no <= 8) return b[bit_no-1];
        if (p != 0 && bit_no == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic push(input int i, input logic [7:0] b);
        fbuf[i][ftail[i] % 64] = b;
        ebuf[i][etail[i] % 64] = b;
        ftail[i]++;
        etail[i]++;
    endtask

    task automatic mon(input int i);
        int         plen;
        logic [7:0] b;
        logic [7:0] dec;
        logic       par;
        bit         ok, aborted, skip, pend, g;
        skip = 0;
        forever begin
            if (!skip) @(negedge clk);
            skip = 0;
            if (rst && tx_w[i] == 1'b0) begin
                plen = (10 + i) * CPB;
                b = 8'h00;
                if (ehead[i] == etail[i]) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_frame dut%0d: start bit seen, required idle line", i);
                end else begin
                    b = ebuf[i][ehead[i] % 64];
                    ehead[i]++;
                end
                ok = 1; aborted = 0; dec = '0; par = 1'b0;
                for (int k = 0; k < plen; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!rst) begin
                        aborted = 1;
                        break;
                    end
                    if (tx_w[i] !== exp_level(b, i, k)) ok = 0;
                    if (frame_done_w[i] !== (k == plen - 1)) ok = 0;
                    if (busy_w[i] !== 1'b1 || fifo_rd_w[i] !== 1'b0) ok = 0;
                    if (k % CPB == CPB / 2) begin
                        if (k / CPB >= 1 && k / CPB <= 8) dec[k/CPB-1] = tx_w[i];
                        if (k / CPB == 9 && i == 1) par = tx_w[i];
                    end
                end
                if (!aborted) begin
                    $display("dut%0d frame: sent 0x%02h decoded 0x%02h", i, b, dec);
                    n_vec++;
                    if (!ok) begin
                        n_err++;
                        $display("FAIL frame dut%0d: waveform/frame_done/busy wrong for byte 0x%02h over %0d cycles", i, b, plen);
                    end
                    n_vec++;
                    if (dec !== b) begin
                        n_err++;
                        $display("FAIL byte dut%0d: decoded 0x%02h, required 0x%02h", i, dec, b);
                    end
                    if (i == 1) begin
                        n_vec++;
                        if (par !== ^b) begin
                            n_err++;
                            $display("FAIL parity dut%0d: got %0b, required %0b", i, par, ^b);
                        end
                    end
                    pend = enable && (fhead[i] != ftail[i]);
                    if (pend) begin
                        @(negedge clk);
                        g = rst && fifo_rd_w[i] === 1'b1 && tx_w[i] === 1'b1;
                        @(negedge clk);
                        g = g && rst && fifo_rd_w[i] === 1'b0 && tx_w[i] === 1'b1 && busy_w[i] === 1'b1;
                        @(negedge clk);
                        if (rst) begin
                            g = g && tx_w[i] === 1'b0;
                            n_vec++;
                            if (!g) begin
                                n_err++;
                                $display("FAIL gap dut%0d: next start bit not exactly 2 cycles after stop, tx=%0b required 0", i, tx_w[i]);
                            end
                            skip = (tx_w[i] == 1'b0);
                        end
                    end else begin
                        @(negedge clk);
                        if (rst) begin
                            n_vec++;
                            if (busy_w[i] !== 1'b0 || fifo_rd_w[i] !== 1'b0) begin
                                n_err++;
                                $display("FAIL to_idle dut%0d: busy=%0b fifo_rd=%0b, required 0 0", i, busy_w[i], fifo_rd_w[i]);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(fhead[0] == ftail[0] && fhead[1] == ftail[1] && ehead[0] == etail[0] &&
                     ehead[1] == etail[1] && !busy_w[0] && !busy_w[1]) && n < budget);
        repeat (2) @(negedge clk);
        n_vec++;
        if (n >= budget) begin
            n_err++;
            $display("FAIL drain: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic wait_start(input int i, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_w[i] !== 1'b0 && n < budget);
        if (n >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL start_timeout dut%0d: no start bit in %0d cycles", i, budget);
        end
    endtask

    task automatic check_quiet(input string name, input int cycles);
        bit bad [2];
        bad[0] = 0;
        bad[1] = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                if (fifo_rd_w[i] !== 1'b0 || busy_w[i] !== 1'b0 || tx_w[i] !== 1'b1) bad[i] = 1;
        end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (bad[i]) begin
                n_err++;
                $display("FAIL %s dut%0d: fifo_rd/busy/tx not 0/0/1 during %0d quiet cycles", name, i, cycles);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 2; i++) begin
            fhead[i] = 0; ftail[i] = 0; ehead[i] = 0; etail[i] = 0;
            fifo_dout_r[i] = 8'h00;
        end
        rst = 1'b0;
        enable = 1'b0;
        fork
            mon(0);
            mon(1);
        join_none

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || fifo_rd_w[i] !== 1'b0 || frame_done_w[i] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state dut%0d: tx=%0b busy=%0b rd=%0b done=%0b, required 1 0 0 0",
                         i, tx_w[i], busy_w[i], fifo_rd_w[i], frame_done_w[i]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        enable = 1'b1;

        check_quiet("empty_idle", 100);

        @(posedge clk); #1;
        push(0, 8'h55);
        wait_idle(400);

        @(posedge clk); #1;
        push(0, 8'hA5);
        push(0, 8'h3C);
        wait_idle(400);

        @(posedge clk); #1;
        push(1, 8'h07);
        wait_idle(400);

        // Enable dropped during START: frame completes, second byte waits.
        @(posedge clk); #1;
        push(0, 8'($urandom));
        push(0, 8'($urandom));
        wait_start(0, 50);
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (45) @(negedge clk);
        check_quiet("enable_hold", 60);
        n_vec++;
        if (fhead[0] == ftail[0]) begin
            n_err++;
            $display("FAIL enable_hold_fifo dut0: fifo drained, required 1 byte left");
        end
        @(posedge clk); #1;
        enable = 1'b1;
        wait_idle(400);

        for (int r = 0; r < 20; r++) begin
            int d;
            int nb;
            @(posedge clk); #1;
            d = int'($urandom_range(0, 1));
            nb = int'($urandom_range(1, 3));
            for (int j = 0; j < nb; j++) push(d, 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 40)) @(posedge clk);
                #1;
                enable = 1'b0;
                repeat ($urandom_range(1, 30)) @(posedge clk);
                #1;
                enable = 1'b1;
            end
            repeat ($urandom_range(0, 60)) @(posedge clk);
        end
        #1;
        enable = 1'b1;
        wait_idle(5000);

        // Reset during DATA bit 3 of 0xC3 (that bit is 0 on the line).
        @(posedge clk); #1;
        push(0, 8'hC3);
        wait_start(0, 50);
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_vec++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || fifo_rd_w[0] !== 1'b0 || frame_done_w[0] !== 1'b0) begin
            n_err++;
            $display("FAIL rst_async dut0: tx=%0b busy=%0b rd=%0b done=%0b, required 1 0 0 0",
                     tx_w[0], busy_w[0], fifo_rd_w[0], frame_done_w[0]);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check_quiet("post_rst", 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
